sobel_calc: RTL and testbench

//  Consumer end of the 3x3 window interface: captures sobel_matrix on each sobel_ready strobe.

---
 rtl/sobel_calc.sv | 109 ++++++++++
 tb/tb_sobel_calc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_calc.sv
// sobel_calc: captures a 3x3 window per strobe, computes |Gx|+|Gy| (clamped or binarized), queues it in a FIFO.
// Strobe in cycle N -> FIFO push at end of N+2; no stall, a full FIFO drops new results and sets sticky overflow.
module sobel_calc #(
   parameter int         FIFO_DEPTH = 4,
   parameter bit         THRESH_EN  = 1'b0,
   parameter logic [7:0] THRESHOLD  = 8'd128
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [2:0][2:0][7:0]        sobel_matrix,
   input  logic                        sobel_ready,
   input  logic                        out_ready,
   output logic [7:0]                  edge_pixel,
   output logic                        out_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        busy,
   output logic                        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      return 10'(a) + {1'b0, b, 1'b0} + 10'(c);
   endfunction

   // S1: window capture
   logic                 s1_v_q;
   logic [2:0][2:0][7:0] pix_q;

   always_ff @(posedge clk) begin
      if (rst) s1_v_q <= 1'b0;
      else     s1_v_q <= sobel_ready;
      if (sobel_ready) pix_q <= sobel_matrix;
   end

   // S2: signed gradients
   logic               s2_v_q;
   logic signed [10:0] gx_d, gy_d, gx_q, gy_q;

   assign gx_d = $signed({1'b0, wsum(pix_q[0][2], pix_q[1][2], pix_q[2][2])})
               - $signed({1'b0, wsum(pix_q[0][0], pix_q[1][0], pix_q[2][0])});
   assign gy_d = $signed({1'b0, wsum(pix_q[2][0], pix_q[2][1], pix_q[2][2])})
               - $signed({1'b0, wsum(pix_q[0][0], pix_q[0][1], pix_q[0][2])});

   always_ff @(posedge clk) begin
      if (rst) s2_v_q <= 1'b0;
      else     s2_v_q <= s1_v_q;
      gx_q <= gx_d;
      gy_q <= gy_d;
   end

   // S3: magnitude and output pixel; its register is the FIFO entry itself
   logic [10:0] gx_abs, gy_abs, mag;
   logic [7:0]  res_pix;

   assign gx_abs = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
   assign gy_abs = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
   assign mag    = gx_abs + gy_abs;

   always_comb begin
      res_pix = 8'd0;
      if (THRESH_EN) res_pix = (mag >= {3'b000, THRESHOLD}) ? 8'hFF : 8'h00;
      else           res_pix = (mag > 11'd255) ? 8'hFF : mag[7:0];
   end

   // Output FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q;
   logic          push, pop, full, wr_en;

   assign full      = (cnt_q == FULL_CNT);
   assign out_valid = (cnt_q != '0);
   assign pop       = out_valid && out_ready;
   assign push      = s2_v_q;
   // A full FIFO still accepts the push when the head leaves in the same cycle.
   assign wr_en     = push && (!full || pop);

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !wr_en) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= res_pix;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en)          wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)            rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_d;
         if (push && !wr_en) ovf_q    <= 1'b1;
      end
   end

   assign edge_pixel = out_valid ? mem_q[rd_ptr_q] : 8'd0;
   assign fifo_count = cnt_q;
   assign busy       = s1_v_q | s2_v_q;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_sobel_calc.sv
// Bench for sobel_calc: directed vector table, corner sequences, and random traffic against a queue model.
module tb_sobel_calc;
   typedef logic [2:0][2:0][7:0] mat_t;
   typedef struct { mat_t m; int exp_pix; int exp_thr; } vec_t;
   typedef struct { int due; int v; int vt; } pend_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sobel_ready = 1'b0;
   logic       out_ready = 1'b0;
   mat_t       sobel_matrix = '0;
   logic [7:0] edge_pixel, edge_pixel_t;
   logic       out_valid, out_valid_t, busy, busy_t, overflow, overflow_t;
   logic [2:0] fifo_count, fifo_count_t;

   int checks = 0;
   int failures = 0;

   sobel_calc #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .sobel_matrix(sobel_matrix), .sobel_ready(sobel_ready),
      .out_ready(out_ready), .edge_pixel(edge_pixel), .out_valid(out_valid),
      .fifo_count(fifo_count), .busy(busy), .overflow(overflow));

   sobel_calc #(.FIFO_DEPTH(4), .THRESH_EN(1'b1), .THRESHOLD(8'd64)) dut_t (
      .clk(clk), .rst(rst), .sobel_matrix(sobel_matrix), .sobel_ready(sobel_ready),
      .out_ready(out_ready), .edge_pixel(edge_pixel_t), .out_valid(out_valid_t),
      .fifo_count(fifo_count_t), .busy(busy_t), .overflow(overflow_t));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input mat_t m);
      sobel_matrix = m;
      sobel_ready  = 1'b1;
      tick();
      sobel_ready  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic mat_t mk_cols(input int c0, input int c1, input int c2);
      mat_t m;
      for (int r = 0; r < 3; r++) begin
         m[r][0] = 8'(c0);
         m[r][1] = 8'(c1);
         m[r][2] = 8'(c2);
      end
      return m;
   endfunction

   function automatic mat_t rnd_mat();
      mat_t m;
      int   hi;
      hi = ($urandom_range(0, 2) == 0) ? 15 : 255;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            m[r][c] = 8'($urandom_range(0, hi));
      return m;
   endfunction

   function automatic int ref_pix(input mat_t m, input bit ten, input int th);
      int p[3][3];
      int gx, gy, mag;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[r][c] = int'(m[r][c]);
      gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
      gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (ten) return (mag >= th) ? 255 : 0;
      return (mag > 255) ? 255 : mag;
   endfunction

   vec_t  vecs[10];
   mat_t  tmp;
   pend_t pend[$];
   int    q[$];
   int    qt[$];
   bit    exp_ovf;

   initial begin
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_edge_pixel", edge_pixel, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b0;

      vecs[0] = '{mk_cols(100, 100, 100), 0, 0};
      vecs[1] = '{mk_cols(0, 128, 255), 255, 255};
      vecs[2] = '{mk_cols(0, 0, 10), 40, 0};
      vecs[3] = '{mk_cols(50, 0, 0), 200, 255};
      tmp = '0; tmp[2][0] = 8'd20; tmp[2][1] = 8'd20; tmp[2][2] = 8'd20;
      vecs[4] = '{tmp, 80, 255};
      tmp = '0; tmp[0][0] = 8'd255;
      vecs[5] = '{tmp, 255, 255};
      tmp = '0; tmp[0][0] = 8'd3;
      vecs[6] = '{tmp, 6, 0};
      vecs[7] = '{mk_cols(0, 0, 16), 64, 255};
      tmp = '0; tmp[2][2] = 8'd127;
      vecs[8] = '{tmp, 254, 255};
      tmp = '0; tmp[2][2] = 8'd128;
      vecs[9] = '{tmp, 255, 255};

      for (int i = 0; i < 10; i++) begin
         out_ready = 1'b1;
         strobe(vecs[i].m);
         chk($sformatf("v%0d_busy_n1", i), busy, 1);
         chk($sformatf("v%0d_valid_n1", i), out_valid, 0);
         tick();
         chk($sformatf("v%0d_valid_n2", i), out_valid, 0);
         tick();
         chk($sformatf("v%0d_valid_n3", i), out_valid, 1);
         chk($sformatf("v%0d_pix", i), edge_pixel, vecs[i].exp_pix);
         chk($sformatf("v%0d_pix_thr", i), edge_pixel_t, vecs[i].exp_thr);
         chk($sformatf("v%0d_busy_n3", i), busy, 0);
         tick();
         chk($sformatf("v%0d_popped", i), out_valid, 0);
         chk($sformatf("v%0d_count", i), fifo_count, 0);
      end

      // Overflow: five results into a four-entry FIFO with no drain
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) strobe(mk_cols(0, 0, k));
      repeat (3) tick();
      chk("ovf_count", fifo_count, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_flag_thr", overflow_t, 1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ovf_pop%0d", k), edge_pixel, 4*k);
         tick();
      end
      chk("ovf_drained", out_valid, 0);
      chk("ovf_sticky", overflow, 1);
      do_reset();
      chk("ovf_cleared", overflow, 0);

      // Full FIFO with simultaneous push and pop
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) strobe(mk_cols(0, 0, k));
      repeat (3) tick();
      chk("full_count", fifo_count, 4);
      strobe(mk_cols(0, 0, 5));
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pp_count", fifo_count, 4);
      chk("pp_overflow", overflow, 0);
      out_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         chk($sformatf("pp_pop%0d", k), edge_pixel, 4*k);
         tick();
      end
      chk("pp_empty", out_valid, 0);

      // Reset lands while a sample is in flight; a strobe during reset is ignored
      out_ready = 1'b1;
      strobe(mk_cols(0, 0, 10));
      rst = 1'b1;
      sobel_matrix = mk_cols(0, 0, 20);
      sobel_ready = 1'b1;
      tick();
      rst = 1'b0;
      sobel_ready = 1'b0;
      chk("rip_busy", busy, 0);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rip_valid%0d", k), out_valid, 0);
         chk($sformatf("rip_count%0d", k), fifo_count, 0);
         tick();
      end
      chk("rip_pix", edge_pixel, 0);
      chk("rip_ovf", overflow, 0);

      // Random traffic against a queue model
      do_reset();
      exp_ovf = 1'b0;
      for (int c = 0; c < 400; c++) begin
         chk("rnd_valid", out_valid, (q.size() != 0) ? 1 : 0);
         chk("rnd_count", fifo_count, q.size());
         chk("rnd_pix", edge_pixel, (q.size() != 0) ? q[0] : 0);
         chk("rnd_pix_thr", edge_pixel_t, (qt.size() != 0) ? qt[0] : 0);
         chk("rnd_ovf", overflow, exp_ovf);
         sobel_ready = ($urandom_range(0, 9) < 6);
         out_ready   = 1'($urandom_range(0, 1));
         if (sobel_ready) begin
            tmp = rnd_mat();
            sobel_matrix = tmp;
            pend.push_back('{c + 2, ref_pix(tmp, 1'b0, 0), ref_pix(tmp, 1'b1, 64)});
         end
         if (q.size() != 0 && out_ready) begin
            void'(q.pop_front());
            void'(qt.pop_front());
         end
         if (pend.size() != 0 && pend[0].due == c) begin
            if (q.size() < 4) begin
               q.push_back(pend[0].v);
               qt.push_back(pend[0].vt);
            end else begin
               exp_ovf = 1'b1;
            end
            void'(pend.pop_front());
         end
         tick();
      end
      sobel_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
